snake_collision_scanner: RTL and testbench
==========================================

Name: snake_collision_scanner

Overview:
- Parametrised, sequential successor to the single-apple collision checker.
- Once per game tick it latches the serialised snake body and up to NumApples apple positions, then scans body segments one per clock.
- Reports per-apple eat flags, wall collision, body collision and a sticky game-over flag, with a start/busy/done handshake.
- Sits between the snake movement logic and the game-state controller.

Parameters:
- MaxSegments, 128, capacity of the snake location buses (head = index 0).
- XWidth, 8, bits per X coordinate.
- YWidth, 9, bits per Y coordinate.
- NumApples, 2, number of apple channels.
- SegWidth, 10, segment width in pixels.
- SegHeight, 10, segment height in pixels.
- AppleWidth, 10, apple width in pixels.
- AppleHeight, 10, apple height in pixels.
- BorderThickness, 10, wall thickness in pixels.
- DisplayWidth, 240, display width in pixels.
- DisplayHeight, 320, display height in pixels.

Ports:
- clock  input  1  50 MHz system clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  one-cycle scan request, one per game tick.
- snakeLocX  input  MaxSegments*XWidth  segment i X at bits [i*XWidth +: XWidth].
- snakeLocY  input  MaxSegments*YWidth  segment i Y at bits [i*YWidth +: YWidth].
- size  input  $clog2(MaxSegments)+1  number of valid segments, head included.
- appleLocX  input  NumApples*XWidth  apple n X.
- appleLocY  input  NumApples*YWidth  apple n Y.
- appleValid  input  NumApples  apple n present.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse; results are valid.
- appleEaten  output  NumApples  per-apple eat flags, updated on done.
- wallCollision  output  1  head overlaps a wall, updated on done.
- bodyCollision  output  1  head overlaps a body segment, updated on done.
- collision  output  1  sticky game-over flag.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; latched buffers cleared.
- Overlap test for rectangles A and B: A.x < B.x+B.w and B.x < A.x+A.w, and the same for y. Compute sums one bit wider than the coordinate so there is no wrap.
- Wall hit: head x < BorderThickness, or x+SegWidth > DisplayWidth-BorderThickness, or the equivalent tests in y.
- States:
  - IDLE: busy=0. On start=1, latch all inputs into internal registers, set effective size = min(size, MaxSegments), go to HEAD.
  - HEAD (1 cycle): evaluate the wall test and every apple test in parallel against the latched head. Apple n counts only if appleValid[n]=1. Results go to internal accumulators. If effective size <= 1, go to DONE; otherwise set the index to 1 and go to SCAN.
  - SCAN: test segment[index] against the head, one segment per cycle, and OR the result into the body accumulator. When index = effective size-1, go to DONE; otherwise increment the index. Scanning does not stop early on a hit.
  - DONE (1 cycle): copy accumulators to appleEaten, wallCollision and bodyCollision. Pulse done=1. Set collision=1 if the wall or body result is 1. Return to IDLE.
- busy=1 in HEAD, SCAN and DONE.
- Latency: start to done = 2 cycles for effective size <= 1, else effective size + 1 cycles.
- start while busy=1 is ignored; no queuing.
- Inputs may change after the start cycle; only the latched copy is used.
- size=0: treated as a head-only scan.
- size > MaxSegments: clamped to MaxSegments.
- appleEaten, wallCollision and bodyCollision hold their values until the next done.
- collision stays 1 until reset.
- Reset asserted mid-scan: immediately IDLE, outputs 0, no done pulse.

Optional Feature:
- WALL_WRAP_EN defined: the wall test is not built; wallCollision is tied to 0; collision comes from body hits only (wrap-around play field).
- WALL_WRAP_EN undefined: wall checking as described above.

Test Plan:
- Reset, then head (100,160), size=3, body (110,160),(120,160), apples invalid; start -> done 4 cycles after start; all flags 0; collision=0.
- Head (100,160), apple0 (105,165) valid, apple1 (50,50) valid; start -> appleEaten=2'b01 on done; collision=0.
- Head (5,100), size=1; start -> done 2 cycles after start; wallCollision=1; collision=1 and still 1 after a further clean scan. With WALL_WRAP_EN defined: wallCollision=0, collision=0.
- size=5, segment4 = head (100,160); start -> bodyCollision=1 on done at cycle 6; segment4 moved to (130,160) with head unchanged -> bodyCollision=0.
- start pulsed again while busy, and snakeLocX changed during the scan -> a single done; results match the latched data.
- Reset driven to 0 mid-SCAN with size=100 -> busy=0 and outputs 0 at once; no done pulse; a fresh start after release works normally.

Source files
------------

// File: rtl/snake_collision_scanner.sv
// Per-tick head/apple/wall/body collision scanner, one body segment per clock.
// Define WALL_WRAP_EN to drop wall checking for a wrap-around play field.
module snake_collision_scanner #(
  parameter int MaxSegments     = 128,
  parameter int XWidth          = 8,
  parameter int YWidth          = 9,
  parameter int NumApples       = 2,
  parameter int SegWidth        = 10,
  parameter int SegHeight       = 10,
  parameter int AppleWidth      = 10,
  parameter int AppleHeight     = 10,
  parameter int BorderThickness = 10,
  parameter int DisplayWidth    = 240,
  parameter int DisplayHeight   = 320
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [MaxSegments*XWidth-1:0]     snakeLocX,
  input  logic [MaxSegments*YWidth-1:0]     snakeLocY,
  input  logic [$clog2(MaxSegments):0]      size,
  input  logic [NumApples*XWidth-1:0]       appleLocX,
  input  logic [NumApples*YWidth-1:0]       appleLocY,
  input  logic [NumApples-1:0]              appleValid,
  output logic                              busy,
  output logic                              done,
  output logic [NumApples-1:0]              appleEaten,
  output logic                              wallCollision,
  output logic                              bodyCollision,
  output logic                              collision
);

  localparam int SizeW = $clog2(MaxSegments) + 1;
  localparam int IdxW  = $clog2(MaxSegments);
  localparam int XW1   = XWidth + 1;
  localparam int YW1   = YWidth + 1;

  typedef enum logic [1:0] {IDLE, HEAD, SCAN, DONE} state_e;

  state_e               state_q, state_d;
  logic [SizeW-1:0]     idx_q, idx_d;
  logic [SizeW-1:0]     size_q, size_d;
  logic [NumApples-1:0] acc_apple_q, acc_apple_d;
  logic                 acc_wall_q, acc_wall_d;
  logic                 acc_body_q, acc_body_d;
  logic [NumApples-1:0] eaten_q, eaten_d;
  logic                 wall_q, wall_d;
  logic                 body_q, body_d;
  logic                 coll_q, coll_d;

  logic [XWidth-1:0]    segx_q [MaxSegments];
  logic [YWidth-1:0]    segy_q [MaxSegments];
  logic [XWidth-1:0]    appx_q [NumApples];
  logic [YWidth-1:0]    appy_q [NumApples];
  logic [NumApples-1:0] appv_q;

  logic                 latch;
  logic [XWidth:0]      hx, sx, ax;
  logic [YWidth:0]      hy, sy, ay;
  logic                 seg_hit, wall_hit;
  logic [NumApples-1:0] apple_hit;

  assign latch = (state_q == IDLE) && start;
  assign hx = {1'b0, segx_q[0]};
  assign hy = {1'b0, segy_q[0]};
  assign sx = {1'b0, segx_q[idx_q[IdxW-1:0]]};
  assign sy = {1'b0, segy_q[idx_q[IdxW-1:0]]};

  // Sums are one bit wider than the coordinates so edges never wrap.
  assign seg_hit = (hx < sx + XW1'(SegWidth))  && (sx < hx + XW1'(SegWidth)) &&
                   (hy < sy + YW1'(SegHeight)) && (sy < hy + YW1'(SegHeight));

  always_comb begin
    apple_hit = '0;
    ax = '0;
    ay = '0;
    for (int n = 0; n < NumApples; n++) begin
      ax = {1'b0, appx_q[n]};
      ay = {1'b0, appy_q[n]};
      apple_hit[n] = appv_q[n] &&
        (hx < ax + XW1'(AppleWidth))  && (ax < hx + XW1'(SegWidth)) &&
        (hy < ay + YW1'(AppleHeight)) && (ay < hy + YW1'(SegHeight));
    end
  end

`ifdef WALL_WRAP_EN
  assign wall_hit = 1'b0;
`else
  assign wall_hit =
    (hx < XW1'(BorderThickness)) ||
    (hx + XW1'(SegWidth) > XW1'(DisplayWidth - BorderThickness)) ||
    (hy < YW1'(BorderThickness)) ||
    (hy + YW1'(SegHeight) > YW1'(DisplayHeight - BorderThickness));
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    size_d      = size_q;
    acc_apple_d = acc_apple_q;
    acc_wall_d  = acc_wall_q;
    acc_body_d  = acc_body_q;
    eaten_d     = eaten_q;
    wall_d      = wall_q;
    body_d      = body_q;
    coll_d      = coll_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d     = HEAD;
        size_d      = (size > SizeW'(MaxSegments)) ? SizeW'(MaxSegments) : size;
        idx_d       = '0;
        acc_apple_d = '0;
        acc_wall_d  = 1'b0;
        acc_body_d  = 1'b0;
      end
      HEAD: begin
        acc_apple_d = apple_hit;
        acc_wall_d  = wall_hit;
        if (size_q <= SizeW'(1)) begin
          state_d = DONE;
        end else begin
          idx_d   = SizeW'(1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_body_d = acc_body_q | seg_hit;
        if (idx_q == size_q - SizeW'(1)) state_d = DONE;
        else idx_d = idx_q + SizeW'(1);
      end
      DONE: begin
        eaten_d = acc_apple_q;
        wall_d  = acc_wall_q;
        body_d  = acc_body_q;
        coll_d  = coll_q | acc_wall_q | acc_body_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      size_q      <= '0;
      acc_apple_q <= '0;
      acc_wall_q  <= 1'b0;
      acc_body_q  <= 1'b0;
      eaten_q     <= '0;
      wall_q      <= 1'b0;
      body_q      <= 1'b0;
      coll_q      <= 1'b0;
      appv_q      <= '0;
      for (int i = 0; i < MaxSegments; i++) begin
        segx_q[i] <= '0;
        segy_q[i] <= '0;
      end
      for (int n = 0; n < NumApples; n++) begin
        appx_q[n] <= '0;
        appy_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      size_q      <= size_d;
      acc_apple_q <= acc_apple_d;
      acc_wall_q  <= acc_wall_d;
      acc_body_q  <= acc_body_d;
      eaten_q     <= eaten_d;
      wall_q      <= wall_d;
      body_q      <= body_d;
      coll_q      <= coll_d;
      if (latch) begin
        appv_q <= appleValid;
        for (int i = 0; i < MaxSegments; i++) begin
          segx_q[i] <= snakeLocX[i*XWidth +: XWidth];
          segy_q[i] <= snakeLocY[i*YWidth +: YWidth];
        end
        for (int n = 0; n < NumApples; n++) begin
          appx_q[n] <= appleLocX[n*XWidth +: XWidth];
          appy_q[n] <= appleLocY[n*YWidth +: YWidth];
        end
      end
    end
  end

  // Results are visible during the done cycle and held afterwards.
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign appleEaten    = done ? acc_apple_q : eaten_q;
  assign wallCollision = done ? acc_wall_q  : wall_q;
  assign bodyCollision = done ? acc_body_q  : body_q;
  assign collision     = coll_q | (done & (acc_wall_q | acc_body_q));

endmodule

// File: tb/tb_snake_collision_scanner.sv
// Directed bench for snake_collision_scanner.
// Honours WALL_WRAP_EN when computing wall expectations.
module tb_snake_collision_scanner;

  localparam int MS = 128;
  localparam int XW = 8;
  localparam int YW = 9;
  localparam int NA = 2;
`ifdef WALL_WRAP_EN
  localparam logic Wall = 1'b0;
`else
  localparam logic Wall = 1'b1;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [MS*XW-1:0] lx = '0;
  logic [MS*YW-1:0] ly = '0;
  logic [7:0]       sz = '0;
  logic [NA*XW-1:0] ax = '0;
  logic [NA*YW-1:0] ay = '0;
  logic [NA-1:0]    av = '0;
  logic             busy, done, wall, body, coll;
  logic [NA-1:0]    eaten;

  int errs = 0;
  int checks = 0;

  snake_collision_scanner dut (
    .clock(clock), .reset(reset), .start(start),
    .snakeLocX(lx), .snakeLocY(ly), .size(sz),
    .appleLocX(ax), .appleLocY(ay), .appleValid(av),
    .busy(busy), .done(done), .appleEaten(eaten),
    .wallCollision(wall), .bodyCollision(body), .collision(coll)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_seg(input int i, input int x, input int y);
    lx[i*XW +: XW] = XW'(x);
    ly[i*YW +: YW] = YW'(y);
  endtask

  task automatic set_apple(input int n, input int x, input int y);
    ax[n*XW +: XW] = XW'(x);
    ay[n*YW +: YW] = YW'(y);
  endtask

  task automatic clear_body();
    for (int i = 1; i < MS; i++) set_seg(i, 30, 30);
  endtask

  task automatic scan(output int lat);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 300) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run(input string tag, input int exp_lat, input int exp_eat,
                     input int exp_wall, input int exp_body, input int exp_coll);
    int lat;
    scan(lat);
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/eaten"}, int'(eaten), exp_eat);
    check({tag, "/wall"}, int'(wall), exp_wall);
    check({tag, "/body"}, int'(body), exp_body);
    check({tag, "/coll"}, int'(coll), exp_coll);
  endtask

  initial begin
    int lat, dones, body_at_done, seen;
    clear_body();
    set_seg(0, 100, 160);
    set_seg(1, 110, 160);
    set_seg(2, 120, 160);
    sz = 8'd3;
    set_apple(0, 105, 165);
    set_apple(1, 50, 50);
    av = 2'b00;
    repeat (3) @(negedge clock);
    check("rst/busy", int'(busy), 0);
    check("rst/done", int'(done), 0);
    check("rst/eaten", int'(eaten), 0);
    check("rst/wall", int'(wall), 0);
    check("rst/body", int'(body), 0);
    check("rst/coll", int'(coll), 0);
    reset = 1'b1;

    run("clean3", 4, 0, 0, 0, 0);

    av = 2'b11;
    run("apple0", 4, 1, 0, 0, 0);
    @(negedge clock);
    check("hold/done", int'(done), 0);
    check("hold/eaten", int'(eaten), 1);

    set_apple(0, 110, 160);
    set_apple(1, 91, 151);
    run("apple_edge", 4, 2, 0, 0, 0);
    av = 2'b01;
    run("apple_invalid", 4, 0, 0, 0, 0);
    av = 2'b00;

    set_seg(0, 220, 300);
    sz = 8'd1;
    run("wall_edge_ok", 2, 0, 0, 0, 0);
    set_seg(0, 100, 160);
    sz = 8'd0;
    run("size0", 2, 0, 0, 0, 0);
    sz = 8'd2;
    run("body_touch", 3, 0, 0, 0, 0);

    set_seg(0, 5, 100);
    sz = 8'd1;
    run("wall_left", 2, 0, int'(Wall), 0, int'(Wall));
    set_seg(0, 221, 200);
    run("wall_right", 2, 0, int'(Wall), 0, int'(Wall));
    set_seg(0, 100, 160);
    run("sticky", 2, 0, 0, 0, int'(Wall));

    clear_body();
    sz = 8'd5;
    set_seg(4, 100, 160);
    run("body_hit", 6, 0, 0, 1, 1);
    set_seg(4, 130, 160);
    run("body_moved", 6, 0, 0, 0, 1);

    clear_body();
    set_seg(127, 100, 160);
    sz = 8'd200;
    run("clamp", 129, 0, 0, 1, 1);
    set_seg(127, 30, 30);

    sz = 8'd5;
    set_seg(4, 130, 160);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dones = 0;
    lat = 0;
    body_at_done = 1;
    for (int c = 1; c <= 12; c++) begin
      if (done) begin
        dones++;
        lat = c;
        body_at_done = int'(body);
      end
      if (c == 2) begin
        start = 1'b1;
        lx[4*XW +: XW] = 8'd100;
      end
      if (c == 3) start = 1'b0;
      @(negedge clock);
    end
    check("busy_start/dones", dones, 1);
    check("busy_start/latency", lat, 6);
    check("busy_start/body", body_at_done, 0);
    set_seg(4, 30, 30);

    sz = 8'd100;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    check("midscan/busy_before", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("midrst/busy", int'(busy), 0);
    check("midrst/done", int'(done), 0);
    check("midrst/eaten", int'(eaten), 0);
    check("midrst/wall", int'(wall), 0);
    check("midrst/body", int'(body), 0);
    check("midrst/coll", int'(coll), 0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    check("midrst/quiet", seen, 0);
    reset = 1'b1;
    sz = 8'd3;
    run("after_rst", 4, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
